// File: rtl/infer_mac_requant.sv
// Dot-product accumulator with bias seed, round-half-up right shift, optional ReLU and
// output saturation; one result per vector on a valid/ready port.
module infer_mac_requant #(
  parameter int PROD_W  = 36,
  parameter int ACC_W   = 48,
  parameter int OUT_W   = 16,
  parameter int SHIFT_W = 6
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PROD_W-1:0]  in_prod,
  input  logic               in_last,
  input  logic [ACC_W-1:0]   bias,
  input  logic [SHIFT_W-1:0] cfg_shift,
  input  logic               cfg_relu,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic               out_sat,
  output logic [15:0]        out_terms
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_ROUND = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  localparam logic [ACC_W-1:0]        ACC_MAX   = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0]        ACC_MIN   = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W:0]   OUT_MAX_W = {{(ACC_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0]   OUT_MIN_W = {{(ACC_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic [SHIFT_W-1:0]      SHIFT_MAX = SHIFT_W'(ACC_W-1);

  // Saturating accumulate; MSB of the result is the clamp flag.
  function automatic logic [ACC_W:0] sat_acc(input logic [ACC_W-1:0] a, input logic [PROD_W-1:0] p);
    logic [ACC_W:0] sum;
    sum = {a[ACC_W-1], a} + {{(ACC_W+1-PROD_W){p[PROD_W-1]}}, p};
    if (sum[ACC_W] == sum[ACC_W-1]) begin
      sat_acc = {1'b0, sum[ACC_W-1:0]};
    end else if (sum[ACC_W]) begin
      sat_acc = {1'b1, ACC_MIN};
    end else begin
      sat_acc = {1'b1, ACC_MAX};
    end
  endfunction

  // Round half toward +inf, shift, optional ReLU, clamp; MSB of the result is the clamp flag.
  function automatic logic [OUT_W:0] requant(input logic [ACC_W-1:0] a, input logic [SHIFT_W-1:0] shift,
                                             input logic relu);
    logic [SHIFT_W-1:0]    s;
    logic [ACC_W:0]        half;
    logic signed [ACC_W:0] r;
    s = (shift > SHIFT_MAX) ? SHIFT_MAX : shift;
    if (s != {SHIFT_W{1'b0}}) begin
      half = {{ACC_W{1'b0}}, 1'b1} << (s - SHIFT_W'(1));
    end else begin
      half = {(ACC_W+1){1'b0}};
    end
    r = $signed({a[ACC_W-1], a} + half) >>> s;
    if (relu && r[ACC_W]) begin
      r = {(ACC_W+1){1'b0}};
    end else begin
      r = r;
    end
    if (r > OUT_MAX_W) begin
      requant = {1'b1, OUT_MAX_W[OUT_W-1:0]};
    end else if (r < OUT_MIN_W) begin
      requant = {1'b1, OUT_MIN_W[OUT_W-1:0]};
    end else begin
      requant = {1'b0, r[OUT_W-1:0]};
    end
  endfunction

  state_t             state_r, state_s;
  logic [ACC_W-1:0]   acc_r;
  logic [15:0]        cnt_r;
  logic               sat_r;
  logic               out_valid_r, out_sat_r;
  logic [OUT_W-1:0]   out_data_r;
  logic [15:0]        out_terms_r;
  logic               beat_s;
  logic [ACC_W:0]     acc_next_s;
  logic [OUT_W:0]     rq_s;

  assign in_ready   = reset_n && ((state_r == ST_IDLE) || (state_r == ST_ACC));
  assign beat_s     = in_valid && in_ready;
  assign acc_next_s = sat_acc((state_r == ST_IDLE) ? bias : acc_r, in_prod);
  assign rq_s       = requant(acc_r, cfg_shift, cfg_relu);
  assign out_valid  = out_valid_r;
  assign out_data   = out_data_r;
  assign out_sat    = out_sat_r;
  assign out_terms  = out_terms_r;

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:  if (beat_s) state_s = in_last ? ST_ROUND : ST_ACC; else state_s = ST_IDLE;
      ST_ACC:   if (beat_s && in_last) state_s = ST_ROUND; else state_s = ST_ACC;
      ST_ROUND: state_s = ST_OUT;
      ST_OUT:   if (out_valid_r && out_ready) state_s = ST_IDLE; else state_s = ST_OUT;
      default:  state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_r <= ST_IDLE;
    else          state_r <= state_s;
  end

  // Accumulator, term counter and registered result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_r       <= {ACC_W{1'b0}};
      cnt_r       <= 16'd0;
      sat_r       <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= {OUT_W{1'b0}};
      out_sat_r   <= 1'b0;
      out_terms_r <= 16'd0;
    end else begin
      if (beat_s) begin
        acc_r <= acc_next_s[ACC_W-1:0];
        // The first beat of a vector restarts the flag and count.
        if (state_r == ST_IDLE) begin
          sat_r <= acc_next_s[ACC_W];
          cnt_r <= 16'd1;
        end else begin
          sat_r <= sat_r | acc_next_s[ACC_W];
          cnt_r <= (cnt_r == 16'hFFFF) ? cnt_r : cnt_r + 16'd1;
        end
      end
      if (state_r == ST_ROUND) begin
        out_valid_r <= 1'b1;
        out_data_r  <= rq_s[OUT_W-1:0];
        out_sat_r   <= sat_r | rq_s[OUT_W];
        out_terms_r <= cnt_r;
      end else if ((state_r == ST_OUT) && out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_infer_mac_requant.sv
// Directed plus randomized bench for infer_mac_requant against an arithmetic reference model.
module tb_infer_mac_requant;

  localparam longint AMAX = 64'sh0000_7FFF_FFFF_FFFF;
  localparam longint AMIN = -AMAX - 64'sd1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready, in_last;
  logic [35:0] in_prod;
  logic [47:0] bias;
  logic [5:0]  cfg_shift;
  logic        cfg_relu;
  logic        out_valid, out_ready, out_sat;
  logic [15:0] out_data, out_terms;

  int checks = 0;
  int errors = 0;
  longint prod_q[$];

  infer_mac_requant dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_prod(in_prod), .in_last(in_last), .bias(bias), .cfg_shift(cfg_shift),
    .cfg_relu(cfg_relu), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat), .out_terms(out_terms)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: integer accumulate with clamping, floor((acc + half) / 2^s), ReLU, clamp to 16 bits.
  task automatic model(input longint b, input int sh, input bit rl,
                       output longint ed, output bit es, output longint et);
    longint acc;
    longint r;
    int     s;
    acc = b;
    es  = 1'b0;
    foreach (prod_q[i]) begin
      acc = acc + prod_q[i];
      if (acc > AMAX) begin acc = AMAX; es = 1'b1; end
      else if (acc < AMIN) begin acc = AMIN; es = 1'b1; end
    end
    s = (sh > 47) ? 47 : sh;
    r = (s == 0) ? acc : ((acc + (64'sd1 <<< (s - 1))) >>> s);
    if (rl && r < 0) r = 0;
    if (r > 32767) begin ed = 32767; es = 1'b1; end
    else if (r < -32768) begin ed = -32768; es = 1'b1; end
    else ed = r;
    et = prod_q.size();
  endtask

  task automatic send_beat(input longint p, input bit last, input longint b);
    int w;
    w = 0;
    in_valid = 1'b1;
    in_prod  = p[35:0];
    in_last  = last;
    bias     = b[47:0];
    while (!in_ready && w < 200) begin @(negedge clk); w++; end
    chk("beat_ready", longint'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_vector(input longint b, input int sh, input bit rl, input int hold, input string tag);
    longint ed, et;
    bit     es;
    model(b, sh, rl, ed, es, et);
    cfg_shift = sh[5:0];
    cfg_relu  = rl;
    out_ready = (hold == 0);
    foreach (prod_q[i]) send_beat(prod_q[i], i == prod_q.size() - 1, b);
    chk({tag, "_round_valid"}, longint'(out_valid), 0);
    @(negedge clk);
    chk({tag, "_valid"}, longint'(out_valid), 1);
    chk({tag, "_data"}, longint'($signed(out_data)), ed);
    chk({tag, "_sat"}, longint'(out_sat), longint'(es));
    chk({tag, "_terms"}, longint'(out_terms), et);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_data"}, longint'($signed(out_data)), ed);
      chk({tag, "_hold_ready"}, longint'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_done_valid"}, longint'(out_valid), 0);
    chk({tag, "_done_ready"}, longint'(in_ready), 1);
  endtask

  function automatic longint rand_sext(input int w);
    longint v;
    v = {$urandom(), $urandom()};
    return (v <<< (64 - w)) >>> (64 - w);
  endfunction

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_prod = 36'd0; in_last = 1'b0; bias = 48'd0;
    cfg_shift = 6'd0; cfg_relu = 1'b0; out_ready = 1'b1;
    #1;
    chk("rst_valid", longint'(out_valid), 0);
    chk("rst_data", longint'(out_data), 0);
    chk("rst_in_ready", longint'(in_ready), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    prod_q = '{100, 200, -50};      run_vector(0, 0, 1'b0, 0, "basic");
    prod_q = '{6};                  run_vector(0, 2, 1'b0, 0, "rnd_p6");
    prod_q = '{-6};                 run_vector(0, 2, 1'b0, 0, "rnd_m6");
    prod_q = '{-7};                 run_vector(0, 2, 1'b0, 0, "rnd_m7");
    prod_q = '{64'sd34359738367};   run_vector(0, 0, 1'b0, 0, "osat");
    prod_q = '{-1000};              run_vector(0, 0, 1'b1, 0, "relu");
    prod_q = '{1, -1};              run_vector(AMAX, 47, 1'b0, 0, "accsat");

    // Backpressure with a pending beat waiting upstream.
    cfg_shift = 6'd0; cfg_relu = 1'b0; out_ready = 1'b0;
    send_beat(300, 1'b1, 0);
    @(negedge clk);
    chk("bp_valid", longint'(out_valid), 1);
    chk("bp_data", longint'($signed(out_data)), 300);
    in_valid = 1'b1; in_prod = 36'd7; in_last = 1'b1; bias = 48'd0;
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", longint'(in_ready), 0);
      chk("bp_hold_data", longint'($signed(out_data)), 300);
      chk("bp_hold_valid", longint'(out_valid), 1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", longint'(out_valid), 0);
    chk("bp_release_ready", longint'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_round_valid", longint'(out_valid), 0);
    @(negedge clk);
    chk("bp_next_valid", longint'(out_valid), 1);
    chk("bp_next_data", longint'($signed(out_data)), 7);
    chk("bp_next_terms", longint'(out_terms), 1);
    @(negedge clk);

    // Asynchronous reset in the middle of a vector.
    send_beat(10, 1'b0, 0);
    send_beat(20, 1'b0, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", longint'(out_valid), 0);
    chk("mid_rst_data", longint'(out_data), 0);
    chk("mid_rst_sat", longint'(out_sat), 0);
    chk("mid_rst_terms", longint'(out_terms), 0);
    chk("mid_rst_in_ready", longint'(in_ready), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    prod_q = '{5};                  run_vector(0, 0, 1'b0, 0, "post_rst");

    // Randomized vectors mixing small and full-range operands.
    for (int v = 0; v < 24; v++) begin
      longint b;
      int     len;
      len = $urandom_range(1, 6);
      prod_q.delete();
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 1) == 0) prod_q.push_back(longint'($urandom_range(0, 4000)) - 2000);
        else                           prod_q.push_back(rand_sext(36));
      end
      b = ($urandom_range(0, 2) == 0) ? rand_sext(48) : longint'($urandom_range(0, 200)) - 100;
      run_vector(b, $urandom_range(0, 63), 1'($urandom_range(0, 1)), $urandom_range(0, 3), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
